// File: rtl/svca_mc_slew.sv
// svca_mc_slew: time-multiplexed, N-channel slewed VCA.
//
// Each incoming unsigned sample is scaled by a per-channel gain. On every
// accepted sample the gain of that channel moves toward the sample's CV by
// (cv - gain) >>> SLEW_SHIFT, with a minimum step of one LSB. The gain
// therefore lands exactly on the CV and never overshoots it. in_snap loads
// the CV directly. One multiplier is shared by all channels across a
// two-stage valid/ready pipeline.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous reset, active low
//   in_valid     input sample present
//   in_ready     block can accept (transfer on in_valid & in_ready)
//   in_channel   channel of the input sample (>= CHANNELS is discarded)
//   in_sample    unsigned input sample
//   in_cv        target gain for the channel
//   in_snap      1 = gain jumps straight to in_cv
//   out_valid    output sample present
//   out_ready    downstream accepts (transfer on out_valid & out_ready)
//   out_channel  channel of the output sample
//   out_sample   scaled sample, (sample * gain) >> CV_WIDTH

module svca_mc_slew #(
    parameter int WIDTH      = 32,
    parameter int CV_WIDTH   = 8,
    parameter int CHANNELS   = 4,
    parameter int SLEW_SHIFT = 4,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_channel,
    input  logic [WIDTH-1:0]    in_sample,
    input  logic [CV_WIDTH-1:0] in_cv,
    input  logic                in_snap,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_channel,
    output logic [WIDTH-1:0]    out_sample
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [CV_WIDTH-1:0] gain [CHANNELS];

    logic                s1_valid;
    logic [CH_W-1:0]     s1_ch;
    logic [WIDTH-1:0]    s1_sample;
    logic [CV_WIDTH-1:0] s1_gain;

    logic                advance;
    logic                accept;
    logic                legal;
    logic [CV_WIDTH-1:0] gain_cur;
    logic signed [CV_WIDTH:0] diff;
    logic signed [CV_WIDTH:0] shifted;
    logic signed [CV_WIDTH:0] step;
    logic [CV_WIDTH-1:0] g_slew;
    logic [CV_WIDTH-1:0] g_new;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && reset_n;
    assign accept   = in_valid && in_ready;
    assign legal    = {1'b0, in_channel} < CH_LIMIT;

    assign gain_cur = legal ? gain[in_channel] : '0;
    assign diff     = $signed({1'b0, in_cv}) - $signed({1'b0, gain_cur});
    assign shifted  = diff >>> SLEW_SHIFT;

    // Small differences would shift to zero and stall short of the CV;
    // force a one-LSB step so the gain always converges exactly.
    always_comb begin
        step = shifted;
        if (shifted == '0 && diff != '0)
            step = diff[CV_WIDTH] ? '1 : (CV_WIDTH + 1)'(1);
    end

    // |step| <= |diff|, so the truncated sum stays inside [0, 2^CV_WIDTH-1].
    assign g_slew = CV_WIDTH'({1'b0, gain_cur} + step);
    assign g_new  = in_snap ? in_cv : g_slew;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++)
                gain[i] <= '0;
            s1_valid    <= 1'b0;
            s1_ch       <= '0;
            s1_sample   <= '0;
            s1_gain     <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_sample  <= '0;
        end else if (advance) begin
            s1_valid <= accept && legal;
            if (accept && legal) begin
                gain[in_channel] <= g_new;
                s1_ch            <= in_channel;
                s1_sample        <= in_sample;
                s1_gain          <= g_new;
            end
            out_valid   <= s1_valid;
            out_channel <= s1_ch;
            out_sample  <= WIDTH'(({{CV_WIDTH{1'b0}}, s1_sample} *
                                   {{WIDTH{1'b0}}, s1_gain}) >> CV_WIDTH);
        end
    end

endmodule

// File: tb/tb_svca_mc_slew.sv
module tb_svca_mc_slew;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_channel;
    logic [31:0] in_sample;
    logic [7:0]  in_cv;
    logic        in_snap;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_channel;
    logic [31:0] out_sample;

    logic        f_in_ready;
    logic        f_out_valid;
    logic [1:0]  f_out_channel;
    logic [31:0] f_out_sample;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    svca_mc_slew #(.WIDTH(32), .CV_WIDTH(8), .CHANNELS(4), .SLEW_SHIFT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
        .in_sample(in_sample), .in_cv(in_cv), .in_snap(in_snap),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_sample(out_sample)
    );

    svca_mc_slew #(.WIDTH(32), .CV_WIDTH(8), .CHANNELS(4), .SLEW_SHIFT(0)) dut_fast (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_channel(in_channel),
        .in_sample(in_sample), .in_cv(in_cv), .in_snap(in_snap),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .out_channel(f_out_channel), .out_sample(f_out_sample)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] sample;
    } exp_t;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] sample;
        logic [7:0]  cv;
        logic        snap;
        logic [31:0] expv;
    } vec_t;

    exp_t exp_q[$];
    int   gain_m[4];
    vec_t vecs[12];

    function automatic int next_gain(int g, int cv, bit snap);
        int d;
        int s;
        if (snap) return cv;
        d = cv - g;
        s = d >>> 4;
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return g + s;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one sample from a negedge; hold it until accepted, then queue its result.
    task automatic send(input logic [1:0] ch, input logic [31:0] smp, input logic [7:0] cv,
                        input logic snap, input bit use_exp, input logic [31:0] expv);
        int   waited;
        int   g;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_channel = ch; in_sample = smp; in_cv = cv; in_snap = snap;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for ch%0d", ch);
        end else begin
            g = next_gain(gain_m[ch], int'(cv), snap);
            gain_m[ch] = g;
            e.ch = ch;
            e.sample = use_exp ? expv : 32'((64'(smp) * 64'(g)) >> 8);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int waited;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset(bit do_check);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        if (do_check) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) gain_m[i] = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard: compare every output transfer against the queue head.
    always begin
        exp_t e;
        @(negedge clk); #2;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch%0d %h expected nothing", out_channel, out_sample);
            end else begin
                e = exp_q.pop_front();
                if (out_channel !== e.ch || out_sample !== e.sample) begin
                    errors++;
                    $display("FAIL sb_data: got ch%0d %h expected ch%0d %h",
                             out_channel, out_sample, e.ch, e.sample);
                end
            end
        end
    end

    initial begin
        logic [1:0]  snap_ch;
        logic [31:0] snap_smp;

        vecs[0]  = '{2'd3, 32'h8000_0000, 8'h40, 1'b1, 32'h2000_0000};
        vecs[1]  = '{2'd3, 32'h8000_0000, 8'h40, 1'b0, 32'h2000_0000};
        vecs[2]  = '{2'd1, 32'h0000_0100, 8'hFF, 1'b0, 32'h0000_000F};
        vecs[3]  = '{2'd1, 32'h0000_0100, 8'hFF, 1'b0, 32'h0000_001E};
        vecs[4]  = '{2'd1, 32'h0000_0100, 8'hFF, 1'b0, 32'h0000_002C};
        vecs[5]  = '{2'd0, 32'hFFFF_FFFF, 8'h00, 1'b0, 32'h0000_0000};
        vecs[6]  = '{2'd2, 32'hFFFF_FFFF, 8'hFF, 1'b1, 32'hFEFF_FFFF};
        vecs[7]  = '{2'd2, 32'h0000_0100, 8'hF0, 1'b0, 32'h0000_00FE};
        vecs[8]  = '{2'd2, 32'h0000_0100, 8'hF0, 1'b0, 32'h0000_00FD};
        vecs[9]  = '{2'd0, 32'h0000_0100, 8'h03, 1'b0, 32'h0000_0001};
        vecs[10] = '{2'd3, 32'h0000_0200, 8'h41, 1'b0, 32'h0000_0082};
        vecs[11] = '{2'd1, 32'h0001_0000, 8'h2C, 1'b0, 32'h0000_2C00};

        reset_n = 1'b0; in_valid = 1'b0; in_channel = '0; in_sample = '0;
        in_cv = '0; in_snap = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) gain_m[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid",   {31'd0, out_valid}, 32'd0);
        check("reset_out_sample",  out_sample, 32'd0);
        check("reset_out_channel", {30'd0, out_channel}, 32'd0);
        check("reset_in_ready",    {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full-scale gain, immediate slew; result two edges after accept.
        send(2'd0, 32'h8000_0000, 8'hFF, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_not_yet", {31'd0, f_out_valid}, 32'd0);
        @(negedge clk); #1;
        check("lat_valid",   {31'd0, f_out_valid}, 32'd1);
        check("lat_sample",  f_out_sample, 32'h7F80_0000);
        check("lat_channel", {30'd0, f_out_channel}, 32'd0);
        check("lat_ready",   {31'd0, f_in_ready}, 32'd1);
        drain();

        pulse_reset(1'b0);
        for (int i = 0; i < 12; i++)
            send(vecs[i].ch, vecs[i].sample, vecs[i].cv, vecs[i].snap, 1'b1, vecs[i].expv);
        drain();

        // Ramp ch1 all the way up; it must settle on 255 exactly.
        for (int i = 0; i < 80; i++)
            send(2'd1, 32'h0000_0100, 8'hFF, 1'b0, 1'b0, 32'd0);
        send(2'd1, 32'h0000_0100, 8'hFF, 1'b0, 1'b1, 32'h0000_00FF);
        send(2'd1, 32'h0000_0100, 8'hFF, 1'b0, 1'b1, 32'h0000_00FF);
        drain();

        // Snap ch2 to 200 then slew down to exactly 0; others untouched.
        send(2'd2, 32'h0000_0100, 8'd200, 1'b1, 1'b1, 32'd200);
        for (int i = 0; i < 80; i++)
            send(2'd2, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 32'd0);
        send(2'd2, 32'h0000_0100, 8'h00, 1'b0, 1'b1, 32'd0);
        send(2'd3, 32'h0000_0200, 8'h41, 1'b0, 1'b1, 32'h0000_0082);
        send(2'd0, 32'h0000_0100, 8'h01, 1'b0, 1'b1, 32'h0000_0001);
        send(2'd1, 32'h0000_0100, 8'hFF, 1'b0, 1'b1, 32'h0000_00FF);
        drain();

        // Back-pressure: five stalled cycles in the middle of a stream.
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(2'(i % 4), $urandom, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 32'd0);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                #2;
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                snap_ch  = out_channel;
                snap_smp = out_sample;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk); #2;
                    check("stall_sample",   out_sample, snap_smp);
                    check("stall_channel",  {30'd0, out_channel}, {30'd0, snap_ch});
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++)
            send(2'(i), 32'h1234_5678, 8'hFF, 1'b0, 1'b0, 32'd0);
        pulse_reset(1'b1);
        send(2'd1, 32'h0000_0100, 8'hFF, 1'b0, 1'b1, 32'h0000_000F);
        send(2'd2, 32'h0000_0100, 8'hFF, 1'b0, 1'b1, 32'h0000_000F);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
